// File: rtl/inst_issue_queue.sv
// FWFT instruction queue between the instruction loader and topcontrol, tracking program progress.
// Optional per-type pop statistics are enabled by defining INST_QUEUE_STATS_EN.
module inst_issue_queue #(
  parameter int INST_LEN   = 220,
  parameter int DEPTH_LOG2 = 5,
  parameter int PROG_LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PROG_LEN_W-1:0] prog_len,
  output logic                  busy,
  output logic                  prog_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [INST_LEN-1:0]   wr_data,
  output logic [INST_LEN-1:0]   instruct,
  output logic                  inst_empty,
  input  logic                  inst_req,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  underflow,
  output logic [PROG_LEN_W-1:0] stat_comp_cnt,
  output logic [PROG_LEN_W-1:0] stat_load_cnt,
  output logic [PROG_LEN_W-1:0] stat_store_cnt
);
  localparam int DEPTH = 2**DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q;
  logic [INST_LEN-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic [PROG_LEN_W-1:0] len_q, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [INST_LEN-1:0]   hold_q;
  logic                  underflow_q;
  logic                  full, empty, do_wr, do_pop, start_acc;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign wr_ready  = (state_q == RUN) && !full && (wr_cnt_q < len_q);
  assign do_wr     = wr_valid && wr_ready;
  assign do_pop    = inst_req && !empty;
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign wr_cnt_d  = wr_cnt_q + PROG_LEN_W'(do_wr);
  assign rd_cnt_d  = rd_cnt_q + PROG_LEN_W'(do_pop);

  // While empty the output keeps the last popped head, which is 0 out of reset.
  assign instruct   = empty ? hold_q : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign inst_empty = empty;
  assign fill_level = wr_ptr_q - rd_ptr_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign prog_done  = (state_q == DONE);
  assign underflow  = underflow_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      hold_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= instruct;
      end
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      if (inst_req && empty) underflow_q <= 1'b1;
      case (state_q)
        IDLE, DONE: if (start_acc) begin
          state_q     <= (prog_len != '0) ? RUN : DONE;
          len_q       <= prog_len;
          wr_cnt_q    <= '0;
          rd_cnt_q    <= '0;
          underflow_q <= 1'b0;
        end
        RUN:     if (wr_cnt_d == len_q) state_q <= DRAIN;
        DRAIN:   if (rd_cnt_d == len_q) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef INST_QUEUE_STATS_EN
  logic [PROG_LEN_W-1:0] comp_q, load_q, store_q;
  logic [3:0]            head_type;

  assign head_type = instruct[3:0];

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      comp_q  <= '0;
      load_q  <= '0;
      store_q <= '0;
    end else if (do_pop) begin
      if (head_type == 4'd0 && comp_q != '1) comp_q <= comp_q + 1'b1;
      if (head_type >= 4'd1 && head_type <= 4'd3 && load_q != '1) load_q <= load_q + 1'b1;
      if (head_type == 4'd4 && store_q != '1) store_q <= store_q + 1'b1;
    end
  end

  assign stat_comp_cnt  = comp_q;
  assign stat_load_cnt  = load_q;
  assign stat_store_cnt = store_q;
`else
  assign stat_comp_cnt  = '0;
  assign stat_load_cnt  = '0;
  assign stat_store_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Randomized + directed bench for inst_issue_queue against a queue-based program model.
module tb_inst_issue_queue;
  localparam int IL = 220;
  localparam int DL = 5;
  localparam int PW = 16;
  localparam int DEPTH = 2**DL;

  logic          clk, rst, start, wr_valid, inst_req;
  logic [PW-1:0] prog_len;
  logic [IL-1:0] wr_data;
  logic          busy, prog_done, wr_ready, inst_empty, underflow;
  logic [IL-1:0] instruct;
  logic [DL:0]   fill_level;
  logic [PW-1:0] stat_comp_cnt, stat_load_cnt, stat_store_cnt;

  inst_issue_queue #(.INST_LEN(IL), .DEPTH_LOG2(DL), .PROG_LEN_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .busy(busy),
    .prog_done(prog_done), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .instruct(instruct), .inst_empty(inst_empty), .inst_req(inst_req),
    .fill_level(fill_level), .underflow(underflow), .stat_comp_cnt(stat_comp_cnt),
    .stat_load_cnt(stat_load_cnt), .stat_store_cnt(stat_store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk = 0, n_pass = 0;
  string scn = "reset";

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s got=%h exp=%h", scn, tag, got, exp);
  endtask

  // Reference model: program phase, a plain queue of words and counts of moved words.
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_e;
  phase_e        m_ph;
  logic [IL-1:0] m_q[$];
  logic [IL-1:0] m_last;
  int            m_len, m_wr, m_rd, m_comp, m_load, m_store;
  bit            m_uf;

  function automatic bit m_wrdy();
    return (m_ph == P_RUN) && (m_q.size() < DEPTH) && (m_wr < m_len);
  endfunction

  task automatic model_edge();
    bit acc, pop;
    int t;
    if (rst) begin
      m_ph = P_IDLE; m_q.delete(); m_last = '0; m_len = 0; m_wr = 0; m_rd = 0;
      m_uf = 0; m_comp = 0; m_load = 0; m_store = 0;
      return;
    end
    acc = wr_valid && m_wrdy();
    pop = inst_req && (m_q.size() != 0);
    if (inst_req && m_q.size() == 0) m_uf = 1;
    if (pop) begin
      m_last = m_q.pop_front();
      m_rd++;
      t = int'(m_last[3:0]);
      if (t == 0) m_comp++;
      else if (t >= 1 && t <= 3) m_load++;
      else if (t == 4) m_store++;
    end
    if (acc) begin
      m_q.push_back(wr_data);
      m_wr++;
    end
    case (m_ph)
      P_IDLE, P_DONE: if (start) begin
        m_len = int'(prog_len); m_wr = 0; m_rd = 0; m_uf = 0;
        m_comp = 0; m_load = 0; m_store = 0;
        m_ph = (prog_len != 0) ? P_RUN : P_DONE;
      end
      P_RUN:   if (m_wr == m_len) m_ph = P_DRAIN;
      P_DRAIN: if (m_rd == m_len) m_ph = P_DONE;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [IL-1:0] eh;
    eh = (m_q.size() == 0) ? m_last : m_q[0];
    chk("wr_ready",   256'(wr_ready),   256'(m_wrdy()));
    chk("inst_empty", 256'(inst_empty), 256'(m_q.size() == 0));
    chk("instruct",   256'(instruct),   256'(eh));
    chk("fill_level", 256'(fill_level), 256'(m_q.size()));
    chk("busy",       256'(busy),       256'(m_ph == P_RUN || m_ph == P_DRAIN));
    chk("prog_done",  256'(prog_done),  256'(m_ph == P_DONE));
    chk("underflow",  256'(underflow),  256'(m_uf));
`ifdef INST_QUEUE_STATS_EN
    chk("stat_comp",  256'(stat_comp_cnt),  256'(m_comp));
    chk("stat_load",  256'(stat_load_cnt),  256'(m_load));
    chk("stat_store", 256'(stat_store_cnt), 256'(m_store));
`else
    chk("stat_zero",  256'({stat_comp_cnt, stat_load_cnt, stat_store_cnt}), 256'(0));
`endif
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic r, input logic s, input int pl, input logic wv,
                      input logic [IL-1:0] wd, input logic rq);
    rst = r; start = s; prog_len = PW'(pl); wr_valid = wv; wr_data = wd; inst_req = rq;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [IL-1:0] rword(input int typ);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    w[3:0] = 4'(typ);
    return w[IL-1:0];
  endfunction

  task automatic idle();       step(0, 0, 0, 0, '0, 0); endtask
  task automatic go(input int len); step(0, 1, len, 0, '0, 0); endtask
  task automatic wr(input logic [IL-1:0] d); step(0, 0, 0, 1, d, 0); endtask
  task automatic pop();        step(0, 0, 0, 0, '0, 1); endtask

  logic [IL-1:0] wa, wb, wc, wn;
  bit            fin;

  initial begin
    rst = 1; start = 0; prog_len = '0; wr_valid = 0; wr_data = '0; inst_req = 0;
    @(negedge clk);
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    idle();

    scn = "fwft3";
    wa = rword(1); wb = rword(2); wc = rword(0);
    go(3); wr(wa); wr(wb); wr(wc);
    chk("head_a", 256'(instruct), 256'(wa));
    pop(); chk("head_b", 256'(instruct), 256'(wb));
    pop(); chk("head_c", 256'(instruct), 256'(wc));
    pop();
    chk("done_after3", 256'({prog_done, busy}), 256'(2'b10));
    idle();

    scn = "full40";
    go(40);
    for (int i = 0; i < 34; i++) wr(rword($urandom_range(0, 7)));
    chk("fill32", 256'(fill_level), 256'(32));
    chk("full_nordy", 256'(wr_ready), 256'(0));
    pop();
    chk("rdy_after_pop", 256'(wr_ready), 256'(1));
    wn = rword(3);
    wr(wn);
    chk("fill_back32", 256'(fill_level), 256'(32));
    fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      step(0, 0, 0, 1, rword($urandom_range(0, 7)), 1);
      fin = prog_done;
    end
    chk("full40_done", 256'(prog_done), 256'(1));

    scn = "underflow";
    go(2); pop();
    chk("uf_set", 256'(underflow), 256'(1));
    chk("uf_fill", 256'(fill_level), 256'(0));
    wr(rword(4)); wr(rword(0)); pop(); pop();
    chk("uf_sticky", 256'({prog_done, underflow}), 256'(2'b11));
    go(0);
    chk("uf_cleared", 256'({prog_done, underflow}), 256'(2'b10));

    scn = "overoffer";
    wa = rword(1); wb = rword(2); wc = rword(3);
    go(2); wr(wa); wr(wb); wr(wc);
    chk("over_fill", 256'(fill_level), 256'(2));
    chk("over_state", 256'({wr_ready, busy}), 256'(2'b01));
    pop(); pop(); idle();
    chk("over_empty", 256'({inst_empty, prog_done}), 256'(2'b11));
    chk("over_hold", 256'(instruct), 256'(wb));

    scn = "wr_pop";
    wa = rword(0); wb = rword(4);
    go(4); wr(wa);
    step(0, 0, 0, 1, wb, 1);
    chk("wp_fill", 256'(fill_level), 256'(1));
    chk("wp_head", 256'(instruct), 256'(wb));
    step(1, 0, 0, 0, '0, 0);
    chk("rst_mid", 256'({inst_empty, wr_ready, busy}), 256'(3'b100));
    idle();

    scn = "stats";
    go(6);
    wr(rword(0)); wr(rword(1)); wr(rword(3)); wr(rword(4)); wr(rword(0)); wr(rword(7));
    for (int i = 0; i < 6; i++) pop();
`ifdef INST_QUEUE_STATS_EN
    chk("stat_mix", 256'({stat_comp_cnt, stat_load_cnt, stat_store_cnt}),
        256'({16'd2, 16'd2, 16'd1}));
`else
    chk("stat_mix", 256'({stat_comp_cnt, stat_load_cnt, stat_store_cnt}), 256'(0));
`endif

    scn = "random";
    for (int p = 0; p < 25; p++) begin
      int pv, pr;
      pv = $urandom_range(20, 95);
      pr = $urandom_range(10, 90);
      go($urandom_range(0, 48));
      fin = prog_done;
      for (int c = 0; c < 1500 && !fin; c++) begin
        logic r, s;
        r = ($urandom_range(0, 599) == 0);
        s = ($urandom_range(0, 15) == 0);
        step(r, s, $urandom_range(0, 48), ($urandom_range(0, 99) < pv),
             rword($urandom_range(0, 15)), ($urandom_range(0, 99) < pr));
        fin = prog_done || r;
      end
      if (!fin) begin
        chk("rand_timeout", 256'(prog_done), 256'(1));
        step(1, 0, 0, 0, '0, 0);
      end
      idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
